// File: rtl/clock_gate_pkg.sv
// rtl/clock_gate_pkg.sv - shared types and helpers for the clock gate controller
package clock_gate_pkg;

    localparam int GATE_STATE_W = 2;

    typedef enum logic [GATE_STATE_W-1:0] {
        GS_RUN   = 2'd0,
        GS_COUNT = 2'd1,
        GS_OFF   = 2'd2,
        GS_WAKE  = 2'd3
    } gate_state_e;

    // Counter width able to hold the larger of the idle and wake terminal counts
    function automatic int cnt_width(input int idle_cycles, input int wake_cycles);
        int m;
        m = (idle_cycles > wake_cycles) ? idle_cycles : wake_cycles;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/clock_gate_timer.sv
// rtl/clock_gate_timer.sv - loadable up-counter with terminal-count compare
module clock_gate_timer #(
    parameter int WIDTH    = 4,
    parameter int TERMINAL = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             inc,
    output logic             tc
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: clear beats load beats increment
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (inc) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Terminal compare only steers next-state logic in the parent
    assign tc = (count_q == WIDTH'(TERMINAL));

endmodule

// File: rtl/clock_gate_ctrl.sv
// rtl/clock_gate_ctrl.sv - idle-detect controller driving a clock gate enable
module clock_gate_ctrl
    import clock_gate_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2,
    parameter int STAT_W      = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_gate_en,
    input  logic                    force_on,
    input  logic [NUM_REQ-1:0]      busy,
    input  logic [NUM_REQ-1:0]      wake_req,
    input  logic                    stat_clr,
    output logic                    clk_en,
    output logic                    clk_ready,
    output logic [GATE_STATE_W-1:0] gate_state,
    output logic [STAT_W-1:0]       gated_cycles
);

    localparam int CNT_W = cnt_width(IDLE_CYCLES, WAKE_CYCLES);

    gate_state_e       state_q, state_d;
    logic              clk_en_q, clk_en_d;
    logic              clk_ready_q, clk_ready_d;
    logic [STAT_W-1:0] gated_cycles_q, gated_cycles_d;

    logic active;
    logic idle_clr, idle_load, idle_inc, idle_tc;
    logic wake_clr, wake_load, wake_inc, wake_tc;

    assign active = (|busy) || (|wake_req) || force_on || !cfg_gate_en;

    // Idle counter: terminal at IDLE_CYCLES-1 since entering COUNT already loads 1
    clock_gate_timer #(
        .WIDTH    (CNT_W),
        .TERMINAL (IDLE_CYCLES - 1)
    ) u_idle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (idle_clr),
        .load     (idle_load),
        .load_val (CNT_W'(1)),
        .inc      (idle_inc),
        .tc       (idle_tc)
    );

    // Wake settle counter: loaded with 1 on leaving OFF
    clock_gate_timer #(
        .WIDTH    (CNT_W),
        .TERMINAL (WAKE_CYCLES)
    ) u_wake_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (wake_clr),
        .load     (wake_load),
        .load_val (CNT_W'(1)),
        .inc      (wake_inc),
        .tc       (wake_tc)
    );

    // Gating FSM next state, registered outputs and timer controls
    always_comb begin
        state_d     = state_q;
        clk_en_d    = clk_en_q;
        clk_ready_d = clk_ready_q;
        idle_clr    = 1'b0;
        idle_load   = 1'b0;
        idle_inc    = 1'b0;
        wake_clr    = 1'b0;
        wake_load   = 1'b0;
        wake_inc    = 1'b0;
        case (state_q)
            GS_RUN: begin
                clk_en_d    = 1'b1;
                clk_ready_d = 1'b1;
                if (!active) begin
                    state_d   = GS_COUNT;
                    idle_load = 1'b1;
                end else begin
                    idle_clr = 1'b1;
                end
            end
            GS_COUNT: begin
                // Activity at the threshold edge wins over gating
                if (active) begin
                    state_d  = GS_RUN;
                    idle_clr = 1'b1;
                end else if (idle_tc) begin
                    state_d     = GS_OFF;
                    clk_en_d    = 1'b0;
                    clk_ready_d = 1'b0;
                    idle_clr    = 1'b1;
                end else begin
                    idle_inc = 1'b1;
                end
            end
            GS_OFF: begin
                if (active) begin
                    state_d     = GS_WAKE;
                    clk_en_d    = 1'b1;
                    clk_ready_d = 1'b0;
                    wake_load   = 1'b1;
                end
            end
            GS_WAKE: begin
                // Settle always completes; idle inputs here do not regate
                if (wake_tc) begin
                    state_d     = GS_RUN;
                    clk_en_d    = 1'b1;
                    clk_ready_d = 1'b1;
                    wake_clr    = 1'b1;
                end else begin
                    wake_inc = 1'b1;
                end
            end
            default: begin
                state_d     = GS_RUN;
                clk_en_d    = 1'b1;
                clk_ready_d = 1'b1;
            end
        endcase
    end

    // Saturating count of cycles spent gated; clear wins over increment
    always_comb begin
        gated_cycles_d = gated_cycles_q;
        if (stat_clr) begin
            gated_cycles_d = '0;
        end else if ((state_q == GS_OFF) && (gated_cycles_q != {STAT_W{1'b1}})) begin
            gated_cycles_d = gated_cycles_q + 1'b1;
        end
    end

    // State and output registers; reset forces the clock on with no wake sequence
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= GS_RUN;
            clk_en_q       <= 1'b1;
            clk_ready_q    <= 1'b1;
            gated_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            clk_en_q       <= clk_en_d;
            clk_ready_q    <= clk_ready_d;
            gated_cycles_q <= gated_cycles_d;
        end
    end

    assign clk_en       = clk_en_q;
    assign clk_ready    = clk_ready_q;
    assign gate_state   = state_q;
    assign gated_cycles = gated_cycles_q;

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// tb/tb_clock_gate_ctrl.sv - directed self-checking bench for clock_gate_ctrl
module tb_clock_gate_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_gate_en;
    logic        force_on;
    logic [3:0]  busy;
    logic [3:0]  wake_req;
    logic        stat_clr;
    logic        clk_en;
    logic        clk_ready;
    logic [1:0]  gate_state;
    logic [31:0] gated_cycles;
    logic        sat_clk_en;
    logic        sat_clk_ready;
    logic [1:0]  sat_gate_state;
    logic [3:0]  sat_gated_cycles;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    clock_gate_ctrl #(
        .NUM_REQ     (4),
        .IDLE_CYCLES (16),
        .WAKE_CYCLES (2),
        .STAT_W      (32)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_gate_en  (cfg_gate_en),
        .force_on     (force_on),
        .busy         (busy),
        .wake_req     (wake_req),
        .stat_clr     (stat_clr),
        .clk_en       (clk_en),
        .clk_ready    (clk_ready),
        .gate_state   (gate_state),
        .gated_cycles (gated_cycles)
    );

    clock_gate_ctrl #(
        .NUM_REQ     (4),
        .IDLE_CYCLES (16),
        .WAKE_CYCLES (2),
        .STAT_W      (4)
    ) u_sat (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_gate_en  (cfg_gate_en),
        .force_on     (force_on),
        .busy         (busy),
        .wake_req     (wake_req),
        .stat_clr     (stat_clr),
        .clk_en       (sat_clk_en),
        .clk_ready    (sat_clk_ready),
        .gate_state   (sat_gate_state),
        .gated_cycles (sat_gated_cycles)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_inputs();
        cfg_gate_en = 1'b1;
        force_on    = 1'b0;
        busy        = '0;
        wake_req    = '0;
        stat_clr    = 1'b0;
    endtask

    task automatic settle_run();
        force_on = 1'b1;
        step(1);
        force_on = 1'b0;
    endtask

    task automatic do_wake();
        wake_req = 4'b0100;
        step(3);
        wake_req = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        step(2);
        checks++; if (gate_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", gate_state); end
        checks++; if (clk_en !== 1'b1) begin failures++; $display("FAIL reset_clk_en got=%0b exp=1", clk_en); end
        checks++; if (clk_ready !== 1'b1) begin failures++; $display("FAIL reset_clk_ready got=%0b exp=1", clk_ready); end
        checks++; if (gated_cycles !== 32'd0) begin failures++; $display("FAIL reset_gated got=%0d exp=0", gated_cycles); end
        rst_n = 1'b1;
    endtask

    task automatic test_idle_gate();
        for (int k = 0; k < 15; k++) begin
            step(1);
            checks++; if (gate_state !== 2'd1 || clk_en !== 1'b1) begin failures++; $display("FAIL idle_count k=%0d got state=%0d en=%0b exp state=1 en=1", k, gate_state, clk_en); end
        end
        step(1);
        checks++; if (gate_state !== 2'd2) begin failures++; $display("FAIL idle_off_state got=%0d exp=2", gate_state); end
        checks++; if (clk_en !== 1'b0 || clk_ready !== 1'b0) begin failures++; $display("FAIL idle_off_outputs got en=%0b rdy=%0b exp en=0 rdy=0", clk_en, clk_ready); end
    endtask

    task automatic test_wake();
        wake_req = 4'b0010;
        step(1);
        checks++; if (gate_state !== 2'd3 || clk_en !== 1'b1 || clk_ready !== 1'b0) begin failures++; $display("FAIL wake_edge0 got st=%0d en=%0b rdy=%0b exp st=3 en=1 rdy=0", gate_state, clk_en, clk_ready); end
        step(1);
        checks++; if (gate_state !== 2'd3 || clk_ready !== 1'b0) begin failures++; $display("FAIL wake_edge1 got st=%0d rdy=%0b exp st=3 rdy=0", gate_state, clk_ready); end
        step(1);
        checks++; if (gate_state !== 2'd0 || clk_en !== 1'b1 || clk_ready !== 1'b1) begin failures++; $display("FAIL wake_edge2 got st=%0d en=%0b rdy=%0b exp st=0 en=1 rdy=1", gate_state, clk_en, clk_ready); end
        wake_req = '0;
    endtask

    task automatic test_busy_pulse();
        settle_run();
        step(10);
        checks++; if (gate_state !== 2'd1) begin failures++; $display("FAIL pulse_pre got=%0d exp=1", gate_state); end
        busy = 4'b0100;
        step(1);
        busy = '0;
        checks++; if (gate_state !== 2'd0) begin failures++; $display("FAIL pulse_run got=%0d exp=0", gate_state); end
        step(15);
        checks++; if (gate_state !== 2'd1 || clk_en !== 1'b1) begin failures++; $display("FAIL pulse_15 got st=%0d en=%0b exp st=1 en=1", gate_state, clk_en); end
        step(1);
        checks++; if (gate_state !== 2'd2 || clk_en !== 1'b0) begin failures++; $display("FAIL pulse_16 got st=%0d en=%0b exp st=2 en=0", gate_state, clk_en); end
        do_wake();
    endtask

    task automatic test_threshold_tie();
        settle_run();
        step(15);
        checks++; if (gate_state !== 2'd1) begin failures++; $display("FAIL tie_pre got=%0d exp=1", gate_state); end
        busy = 4'b0001;
        step(1);
        checks++; if (gate_state !== 2'd0 || clk_en !== 1'b1 || clk_ready !== 1'b1) begin failures++; $display("FAIL tie_run got st=%0d en=%0b rdy=%0b exp st=0 en=1 rdy=1", gate_state, clk_en, clk_ready); end
        busy = '0;
    endtask

    task automatic test_stats();
        force_on = 1'b1;
        stat_clr = 1'b1;
        step(1);
        stat_clr = 1'b0;
        force_on = 1'b0;
        checks++; if (gated_cycles !== 32'd0 || sat_gated_cycles !== 4'd0) begin failures++; $display("FAIL stat_clr_run got=%0d sat=%0d exp=0 sat=0", gated_cycles, sat_gated_cycles); end
        step(16);
        checks++; if (gate_state !== 2'd2) begin failures++; $display("FAIL stat_off got=%0d exp=2", gate_state); end
        step(99);
        wake_req = 4'b1000;
        step(1);
        checks++; if (gated_cycles !== 32'd100) begin failures++; $display("FAIL stat_100 got=%0d exp=100", gated_cycles); end
        checks++; if (sat_gated_cycles !== 4'd15) begin failures++; $display("FAIL stat_sat got=%0d exp=15", sat_gated_cycles); end
        step(2);
        wake_req = '0;
        checks++; if (gate_state !== 2'd0 || gated_cycles !== 32'd100) begin failures++; $display("FAIL stat_hold got st=%0d cnt=%0d exp st=0 cnt=100", gate_state, gated_cycles); end
        step(16);
        step(5);
        checks++; if (gated_cycles !== 32'd105) begin failures++; $display("FAIL stat_105 got=%0d exp=105", gated_cycles); end
        stat_clr = 1'b1;
        step(1);
        stat_clr = 1'b0;
        checks++; if (gated_cycles !== 32'd0) begin failures++; $display("FAIL stat_clr_off got=%0d exp=0", gated_cycles); end
        step(3);
        checks++; if (gated_cycles !== 32'd3) begin failures++; $display("FAIL stat_resume got=%0d exp=3", gated_cycles); end
        do_wake();
    endtask

    task automatic test_reset_mid();
        settle_run();
        step(16);
        checks++; if (gate_state !== 2'd2) begin failures++; $display("FAIL rmid_off got=%0d exp=2", gate_state); end
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        checks++; if (gate_state !== 2'd0 || clk_en !== 1'b1 || clk_ready !== 1'b1) begin failures++; $display("FAIL rmid_off_rst got st=%0d en=%0b rdy=%0b exp st=0 en=1 rdy=1", gate_state, clk_en, clk_ready); end
        step(16);
        wake_req = 4'b0001;
        step(1);
        checks++; if (gate_state !== 2'd3) begin failures++; $display("FAIL rmid_wake got=%0d exp=3", gate_state); end
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        wake_req = '0;
        checks++; if (gate_state !== 2'd0 || clk_en !== 1'b1 || clk_ready !== 1'b1) begin failures++; $display("FAIL rmid_wake_rst got st=%0d en=%0b rdy=%0b exp st=0 en=1 rdy=1", gate_state, clk_en, clk_ready); end
    endtask

    task automatic test_cfg_off();
        cfg_gate_en = 1'b0;
        for (int k = 0; k < 50; k++) begin
            step(1);
            checks++; if (gate_state !== 2'd0 || clk_en !== 1'b1) begin failures++; $display("FAIL cfg_off k=%0d got st=%0d en=%0b exp st=0 en=1", k, gate_state, clk_en); end
        end
        cfg_gate_en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_idle_gate();
        test_wake();
        test_busy_pulse();
        test_threshold_tie();
        test_stats();
        test_reset_mid();
        test_cfg_off();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
